// File: rtl/click_fifo_sync.sv
// click_fifo_sync
//   Clocked FIFO bridging a 2-phase (transition-signalled) bundled-data
//   click pipeline into synchronous logic and back out again.
//
//   Ports
//     clk       : rising-edge clock
//     reset     : asynchronous, active-high reset
//     in_req    : 2-phase request, one transition per incoming token
//     in_data   : bundled data, stable from in_req transition to in_ack transition
//     in_ack    : 2-phase acknowledge (registered)
//     out_req   : 2-phase request (registered)
//     out_data  : bundled data (registered), leads out_req by one cycle
//     out_ack   : 2-phase acknowledge from the consumer
//     count     : entries held in FIFO memory (output register excluded)
//     full      : count == DEPTH
//     empty     : count == 0
module click_fifo_sync #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           DEPTH       = 4,
  parameter int unsigned           SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] VALUE       = '0,
  parameter logic                  PHASE_INIT  = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_req,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    in_ack,
  output logic                    out_req,
  output logic [DATA_WIDTH-1:0]   out_data,
  input  logic                    out_ack,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    O_IDLE = 2'd0,
    O_REQ  = 2'd1,
    O_WAIT = 2'd2
  } o_state_e;

  // Synchronisers for the two asynchronous handshake inputs.
  logic [SYNC_STAGES-1:0] in_req_sync_q;
  logic [SYNC_STAGES-1:0] out_ack_sync_q;
  logic                   in_req_s;
  logic                   out_ack_s;

  // NOTE: sequential state always uses non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_req_sync_q  <= {SYNC_STAGES{PHASE_INIT}};
      out_ack_sync_q <= {SYNC_STAGES{PHASE_INIT}};
    end else begin
      in_req_sync_q  <= {in_req_sync_q[SYNC_STAGES-2:0], in_req};
      out_ack_sync_q <= {out_ack_sync_q[SYNC_STAGES-2:0], out_ack};
    end
  end

  assign in_req_s  = in_req_sync_q[SYNC_STAGES-1];
  assign out_ack_s = out_ack_sync_q[SYNC_STAGES-1];

  // Storage and bookkeeping state.
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_d;
  logic                  in_ack_q;
  logic                  out_req_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  o_state_e              state_q;

  logic full_w;
  logic empty_w;
  logic in_pending;
  logic wr_en;
  logic ld_en;

  assign full_w     = (count_q == CW'(DEPTH));
  assign empty_w    = (count_q == '0);
  // An unacknowledged transition means a token is waiting upstream.
  assign in_pending = in_req_s ^ in_ack_q;
  // full is the pre-edge value, so a same-cycle load never lets a write through.
  assign wr_en      = in_pending & ~full_w;
  assign ld_en      = (state_q == O_IDLE) & ~empty_w;

  always_comb begin
    count_d = count_q;
    unique case ({wr_en, ld_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: the data array carries no reset; pointers and count define which
  // entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  // Input side: accept a pending token when there is room.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ack_q <= PHASE_INIT;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        in_ack_q <= ~in_ack_q;
      end
    end
  end

  // Output FSM: load data, then signal it a cycle later so the consumer
  // sees stable data before the request transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= O_IDLE;
      rd_ptr_q   <= '0;
      out_req_q  <= PHASE_INIT;
      out_data_q <= VALUE;
    end else begin
      unique case (state_q)
        O_IDLE: begin
          if (ld_en) begin
            out_data_q <= mem[rd_ptr_q];
            rd_ptr_q   <= rd_ptr_q + AW'(1);
            state_q    <= O_REQ;
          end
        end
        O_REQ: begin
          out_req_q <= ~out_req_q;
          state_q   <= O_WAIT;
        end
        O_WAIT: begin
          if (out_ack_s == out_req_q) begin
            state_q <= O_IDLE;
          end
        end
        default: state_q <= O_IDLE;
      endcase
    end
  end

  assign in_ack   = in_ack_q;
  assign out_req  = out_req_q;
  assign out_data = out_data_q;
  assign count    = count_q;
  assign full     = full_w;
  assign empty    = empty_w;

endmodule
